fifo_rd_sched: RTL and testbench
================================

# fifo_rd_sched

Read-side burst scheduler for the asynchronous FIFO. It sits in the read clock domain, next to the read-pointer/empty logic, and shares the single FIFO read port between NREQ consumers. Each consumer requests a burst of a given length. The block grants consumers round-robin, pops the FIFO one beat per cycle while data is available, and presents beats through a registered output stage tagged with the winner's index and a last-beat flag.

## Interface
- ASIZE, 4, FIFO address width; informational only, no logic depends on it
- DSIZE, 8, FIFO data width
- NREQ, 4, number of requesters, 2..16
- LW, 4, burst-length field width; field value L means L+1 beats (1..2^LW)
- IW, $clog2(NREQ), requester-index width
- rclk  in  1  read-domain clock; all logic on rising edge
- rrst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester burst request, level
- req_len  in  NREQ*LW  per-requester length field; slice i = [i*LW +: LW]
- gnt  out  NREQ  one-hot grant, registered, held for the whole burst
- rempty  in  1  FIFO empty flag
- rdata  in  DSIZE  FIFO read data, valid whenever rempty=0
- rinc  out  1  FIFO pop strobe, combinational
- out_valid  out  1  output beat valid, registered
- out_data  out  DSIZE  output beat data
- out_id  out  IW  index of the requester that owns the beat
- out_last  out  1  final beat of a burst
- out_ready  in  1  consumer accepts beat
- busy  out  1  state is BURST

## Operation
- States:
  - IDLE: if any req bit is set, pick the winner round-robin, starting the search at ptr and wrapping. Register the one-hot gnt, set cnt = req_len[winner], and go to BURST.
  - BURST: hold the grant and pop beats until the burst is complete.
- ptr behaviour:
  - Reset value 0.
  - Updated to (winner+1) mod NREQ when the burst completes.
- Output stage:
  - A single register holding out_valid, out_data, out_id and out_last.
  - free = !out_valid | out_ready.
- Pop:
  - rinc = BURST & !rempty & free.
  - On pop: load rdata into the output register, out_id = winner index, out_last = (cnt==0), then decrement cnt.
- Burst completion:
  - A pop with cnt==0 returns the block to IDLE, clears gnt and updates ptr.
- Output handshake:
  - If out_valid & out_ready occurs with no pop in the same cycle, clear out_valid.
  - A pop and an out_ready in the same cycle replace the held beat with no bubble.
- Request handling:
  - req and req_len are sampled only in IDLE.
  - Deasserting req during a burst has no effect; the burst always completes.
- FIFO empty:
  - rempty=1 during BURST stalls popping.
  - The block stays in BURST indefinitely and keeps gnt asserted; there is no timeout.
- Reset values: state IDLE, gnt 0, rinc 0, out_valid 0, out_data 0, out_id 0, out_last 0, busy 0, cnt 0, ptr 0.
- Reset mid-burst:
  - rinc drops immediately (asynchronous).
  - Any beat held in the output register is discarded.
  - No further pops occur.

## Timing
- Grant latency:
  - req seen in IDLE at edge t gives gnt and busy high after edge t.
  - The first rinc can occur in the cycle after edge t.
  - out_valid rises one edge after the pop.
- Throughput: 1 beat/cycle inside a burst while rempty=0 and out_ready=1.
- Burst turnaround:
  - Last pop in cycle p: gnt falls and state is IDLE after the edge ending p.
  - The next grant registers one edge later, so there is a single cycle with gnt=0 between back-to-back bursts.
- out_last and the last beat of burst N may still be held while burst N+1 is granted; beats stay in order.
- rinc is never asserted when rempty=1, so the FIFO never underflows.

## Test plan
- **Reset mid-burst:** assert rrst mid-burst →
  - rinc=0 the same cycle;
  - all outputs at reset values;
  - after release, grant restarts from requester 0.
- **Single burst:** req=0001, req_len[0]=3, FIFO preloaded with 0xA0..0xA3, out_ready=1 →
  - gnt=0001 for 4 pop cycles;
  - out_data A0,A1,A2,A3 with out_id=0 and out_last only on A3;
  - exactly 4 rinc pulses.
- **Round-robin:** req=1111, all lengths 0 →
  - grant order 0,1,2,3,0;
  - one gnt=0 cycle between consecutive grants.
- **Empty stall:** grant a burst with FIFO empty →
  - rinc stays 0 and gnt is held;
  - writing one word gives one pop and out_valid 1 cycle later.
- **Backpressure:** out_ready=0 while a beat is held →
  - no rinc, out_data stable;
  - on out_ready=1, held beat taken and next pop in the same cycle, no bubble.

Source files
------------

// File: rtl/fifo_rd_sched.sv
// Read-side burst scheduler: round-robin arbitration of NREQ burst requesters
// over the single FIFO read port, with a registered one-deep output stage.
module fifo_rd_sched #(
  parameter int ASIZE = 4,
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int LW    = 4,
  parameter int IW    = $clog2(NREQ)
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LW-1:0]   req_len,
  output logic [NREQ-1:0]      gnt,
  input  logic                 rempty,
  input  logic [DSIZE-1:0]     rdata,
  output logic                 rinc,
  output logic                 out_valid,
  output logic [DSIZE-1:0]     out_data,
  output logic [IW-1:0]        out_id,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);

  if (NREQ < 2 || NREQ > 16 || ASIZE < 1) begin : g_bad_param
    $error("fifo_rd_sched: NREQ must be 2..16 and ASIZE >= 1");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [LW-1:0]   cnt;
  logic [IW-1:0]   pick;
  logic            found;
  logic            free;
  logic [LW-1:0]   len_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_a[i] = req_len[i*LW +: LW];
  end

  // Round-robin search: first set req bit at or after ptr, wrapping.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign free = !out_valid || out_ready;
  assign rinc = (state == BURST) && !rempty && free;
  assign busy = (state == BURST);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state     <= IDLE;
      gnt       <= '0;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt       <= '0;
            gnt[pick] <= 1'b1;
            win       <= pick;
            cnt       <= len_a[pick];
            state     <= BURST;
          end
        end
        BURST: begin
          if (rinc) begin
            if (cnt == '0) begin
              state <= IDLE;
              gnt   <= '0;
              ptr   <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A pop overwrites the held beat directly, so a same-cycle accept leaves no bubble.
      if (rinc) begin
        out_valid <= 1'b1;
        out_data  <= rdata;
        out_id    <= win;
        out_last  <= (cnt == '0);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: directed scenarios plus random traffic, every cycle
// compared against a beat-counting behavioural model of the scheduler and FIFO.
module tb_fifo_rd_sched;
  localparam int ASIZE = 4;
  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int LW    = 4;
  localparam int IW    = 2;

  logic                rclk = 1'b0;
  logic                rrst;
  logic [NREQ-1:0]     req;
  logic [NREQ*LW-1:0]  req_len;
  logic [NREQ-1:0]     gnt;
  logic                rempty;
  logic [DSIZE-1:0]    rdata;
  logic                rinc;
  logic                out_valid;
  logic [DSIZE-1:0]    out_data;
  logic [IW-1:0]       out_id;
  logic                out_last;
  logic                out_ready;
  logic                busy;

  fifo_rd_sched #(.ASIZE(ASIZE), .DSIZE(DSIZE), .NREQ(NREQ), .LW(LW), .IW(IW)) dut (
    .rclk(rclk), .rrst(rrst), .req(req), .req_len(req_len), .gnt(gnt),
    .rempty(rempty), .rdata(rdata), .rinc(rinc), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and reference model: owner index (-1 = none), beats left in burst, output slot.
  logic [DSIZE-1:0] fifo_q[$];
  int               m_owner, m_left, m_ptr, m_hid;
  bit               m_hv, m_hl;
  logic [DSIZE-1:0] m_hd;

  int               pops_seen;
  logic [DSIZE-1:0] beats[$];
  logic [NREQ-1:0]  grants[$];
  logic [NREQ-1:0]  prev_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_left = 0; m_ptr = 0; m_hid = 0;
    m_hv = 0; m_hl = 0; m_hd = '0;
  endtask

  function automatic logic [LW-1:0] len_of(input int i);
    logic [NREQ*LW-1:0] v;
    v = req_len;
    return v[i*LW +: LW];
  endfunction

  // One clock cycle: inputs already set by caller at the falling edge.
  task automatic cycle();
    bit er;
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? DSIZE'($urandom) : fifo_q[0];
    #1;
    er = (m_owner >= 0) && !rempty && (!m_hv || out_ready);
    chk("rinc",      32'(rinc),      32'(er));
    chk("gnt",       32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("busy",      32'(busy),      32'(m_owner >= 0));
    chk("out_valid", 32'(out_valid), 32'(m_hv));
    chk("out_data",  32'(out_data),  32'(m_hd));
    chk("out_id",    32'(out_id),    32'(m_hid));
    chk("out_last",  32'(out_last),  32'(m_hl));
    if (rinc) pops_seen++;
    if (out_valid && out_ready) beats.push_back(out_data);
    if (gnt != '0 && prev_gnt == '0) grants.push_back(gnt);
    prev_gnt = gnt;

    if (m_owner < 0) begin
      if (req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (m_owner < 0 && req[idx]) m_owner = idx;
        end
        m_left = int'(len_of(m_owner)) + 1;
      end
      if (m_hv && out_ready) m_hv = 0;
    end else if (er) begin
      m_hd = fifo_q[0]; m_hid = m_owner; m_hl = (m_left == 1); m_hv = 1;
      m_left--;
      if (m_left == 0) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end else if (m_hv && out_ready) begin
      m_hv = 0;
    end

    @(posedge rclk);
    if (er) void'(fifo_q.pop_front());
    @(negedge rclk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rinc"},      32'(rinc),      32'd0);
    chk({tag, "_gnt"},       32'(gnt),       32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_id"},    32'(out_id),    32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] exp_rr [5];
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rrst = 1'b1; req = '0; req_len = '0; out_ready = 1'b1;
    rempty = 1'b1; rdata = '0; prev_gnt = '0;
    model_reset();
    @(negedge rclk); @(negedge rclk);
    check_reset_values("por");
    rrst = 1'b0;

    // Single burst of 4 beats from requester 0.
    fifo_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    req = 4'b0001; req_len = '0; req_len[0 +: LW] = 4'd3;
    pops_seen = 0; beats.delete();
    cycle();
    req = '0;
    repeat (7) cycle();
    chk("single_pops", 32'(pops_seen), 32'd4);
    chk("single_nbeats", 32'(beats.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("single_beat", (beats.size() > i) ? 32'(beats[i]) : 32'hFFFF, 32'hA0 + 32'(i));

    // Reset in the middle of a burst owned by requester 1.
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'h30 + 8'(i));
    req = 4'b0010; req_len = '0; req_len[1*LW +: LW] = 4'd7;
    repeat (4) cycle();
    rrst = 1'b1;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge rclk); @(negedge rclk);
    rrst = 1'b0;

    // Round-robin with all requesters active, single-beat bursts.
    fifo_q.delete();
    for (int i = 0; i < 20; i++) fifo_q.push_back(8'(i));
    req = 4'b1111; req_len = '0;
    grants.delete(); prev_gnt = '0;
    repeat (12) cycle();
    chk("rr_count", 32'(grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (grants.size() > i) ? 32'(grants[i]) : 32'd0, 32'(exp_rr[i]));

    // Empty stall: grant with no data, then one word arrives.
    req = 4'b0000;
    repeat (3) cycle();
    fifo_q.delete();
    req = 4'b0100; req_len = '0;
    cycle();
    req = '0;
    repeat (5) cycle();
    fifo_q.push_back(8'h5C);
    repeat (3) cycle();

    // Backpressure: output held while out_ready is low, then streams without bubbles.
    fifo_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    req = 4'b0001; req_len = '0; req_len[0 +: LW] = 4'd3; out_ready = 1'b0;
    cycle();
    req = '0;
    repeat (5) cycle();
    out_ready = 1'b1;
    repeat (6) cycle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        req_len[i*LW +: LW] = ($urandom % 8 == 0) ? LW'($urandom) : LW'($urandom_range(0, 3));
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 10 < 6) fifo_q.push_back(DSIZE'($urandom));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
